// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions: register address width, writeback source
// encodings and load funct3 constants. Decode imports the same package.
package mem_wb_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned FUNCT3_W   = 3;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational load alignment and sign/zero extension.
// Ports:
//   funct3 - load type (LB, LH, LW, LBU, LHU)
//   offset - byte offset within the word (alu_result[1:0])
//   word   - raw SRAM read word
//   data   - aligned, extended load result
// Offset bits below the access size are ignored, so misaligned LH/LW
// simply read the naturally aligned halfword/word.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [1:0]          offset,
  input  logic [XLEN-1:0]     word,
  output logic [XLEN-1:0]     data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte lane selected by the full offset, halfword lane by offset[1] only.
  assign byte_v = 8'(word >> {offset, 3'b000});
  assign half_v = 16'(word >> {offset[1], 4'b0000});

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:   data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback mux.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   stall_i, flush_i       - hold WB contents / replace with a bubble
//   mem_*_i                - instruction fields and candidate results from MEM
//   dmem_rdata_i           - SRAM read word, valid while the load sits in WB
//   RegWrite, waddr_o,
//   wdata_o                - register file write port
//   wb_valid_o             - WB holds a real instruction (forwarding qualifier)
// Because the SRAM word is only valid in the first WB cycle, a stalled load
// captures its aligned value in a hold register and uses it afterwards.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [WB_SEL_W-1:0]   mem_wb_sel_i,
  input  logic [FUNCT3_W-1:0]   mem_funct3_i,
  input  logic [XLEN-1:0]       mem_alu_result_i,
  input  logic [XLEN-1:0]       mem_pc4_i,
  input  logic [XLEN-1:0]       mem_csr_rdata_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  wb_valid_o
);

  logic                  valid_q;
  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] rd_q;
  wb_sel_e               wb_sel_q;
  logic [FUNCT3_W-1:0]   funct3_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       pc4_q;
  logic [XLEN-1:0]       csr_q;
  logic                  hold_valid_q;
  logic [XLEN-1:0]       hold_data_q;

  logic [XLEN-1:0]       load_live;
  logic [XLEN-1:0]       load_data;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (funct3_q),
    .offset (alu_q[1:0]),
    .word   (dmem_rdata_i),
    .data   (load_live)
  );

  // Pipeline register: rst > flush > stall > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      wb_sel_q     <= WB_ALU;
      funct3_q     <= '0;
      alu_q        <= '0;
      pc4_q        <= '0;
      csr_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      hold_valid_q <= 1'b0;
    end else if (stall_i) begin
      // First stalled cycle of a load: keep the word before the SRAM moves on.
      if (valid_q && (wb_sel_q == WB_LOAD) && !hold_valid_q) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= load_live;
      end
    end else begin
      valid_q      <= mem_valid_i;
      reg_write_q  <= mem_reg_write_i;
      rd_q         <= mem_rd_i;
      wb_sel_q     <= wb_sel_e'(mem_wb_sel_i);
      funct3_q     <= mem_funct3_i;
      alu_q        <= mem_alu_result_i;
      pc4_q        <= mem_pc4_i;
      csr_q        <= mem_csr_rdata_i;
      hold_valid_q <= 1'b0;
    end
  end

  assign load_data = hold_valid_q ? hold_data_q : load_live;

  // Writeback source mux.
  always_comb begin
    wdata_o = alu_q;
    case (wb_sel_q)
      WB_ALU:  wdata_o = alu_q;
      WB_LOAD: wdata_o = load_data;
      WB_PC4:  wdata_o = pc4_q;
      WB_CSR:  wdata_o = csr_q;
      default: wdata_o = alu_q;
    endcase
  end

  assign RegWrite   = valid_q & reg_write_q & (rd_q != '0);
  assign waddr_o    = rd_q;
  assign wb_valid_o = valid_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        mem_valid_i;
  logic        mem_reg_write_i;
  logic [4:0]  mem_rd_i;
  logic [1:0]  mem_wb_sel_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_alu_result_i;
  logic [31:0] mem_pc4_i;
  logic [31:0] mem_csr_rdata_i;
  logic [31:0] dmem_rdata_i;
  logic        RegWrite;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        wb_valid_o;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .mem_valid_i      (mem_valid_i),
    .mem_reg_write_i  (mem_reg_write_i),
    .mem_rd_i         (mem_rd_i),
    .mem_wb_sel_i     (mem_wb_sel_i),
    .mem_funct3_i     (mem_funct3_i),
    .mem_alu_result_i (mem_alu_result_i),
    .mem_pc4_i        (mem_pc4_i),
    .mem_csr_rdata_i  (mem_csr_rdata_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .RegWrite         (RegWrite),
    .waddr_o          (waddr_o),
    .wdata_o          (wdata_o),
    .wb_valid_o       (wb_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load alignment vectors: funct3, offset, SRAM word, expected result.
  logic [2:0]  la_f3  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010,
                              3'b001, 3'b010, 3'b000, 3'b100};
  logic [1:0]  la_off [9] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd0};
  logic [31:0] la_word[9] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                              32'h80FF_0000, 32'hDEAD_BEEF, 32'h80FF_1234,
                              32'hCAFE_BABE, 32'h0000_8000, 32'h0000_00FF};
  logic [31:0] la_exp [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'hDEAD_BEEF, 32'h0000_1234,
                              32'hCAFE_BABE, 32'hFFFF_FF80, 32'h0000_00FF};

  task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] csr);
    mem_valid_i      = v;
    mem_reg_write_i  = rw;
    mem_rd_i         = rd;
    mem_wb_sel_i     = sel;
    mem_funct3_i     = f3;
    mem_alu_result_i = alu;
    mem_pc4_i        = pc4;
    mem_csr_rdata_i  = csr;
  endtask

  task automatic bubble();
    set_mem(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
    checks++; if (waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr_o); end
    checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 00000000", wdata_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid_o); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    set_mem(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0000_0104, 32'hAAAA_AAAA);
    dmem_rdata_i = 32'hFFFF_FFFF;
    tick();
    bubble();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b expected 1", RegWrite); end
    checks++; if (waddr_o !== 5'd5) begin errors++; $display("FAIL alu_waddr: got %0d expected 5", waddr_o); end
    checks++; if (wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL alu_wdata: got %h expected 12345678", wdata_o); end
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL alu_wb_valid: got %b expected 1", wb_valid_o); end
  endtask

  task automatic test_wb_sel();
    set_mem(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'h0000_0055, 32'h0000_0204, 32'hC0FF_EE00);
    tick();
    checks++; if (wdata_o !== 32'h0000_0204) begin errors++; $display("FAIL sel_pc4: got %h expected 00000204", wdata_o); end
    set_mem(1'b1, 1'b1, 5'd2, 2'd3, 3'd0, 32'h0000_0055, 32'h0000_0208, 32'hC0FF_EE00);
    tick();
    checks++; if (wdata_o !== 32'hC0FF_EE00) begin errors++; $display("FAIL sel_csr: got %h expected c0ffee00", wdata_o); end
    checks++; if (waddr_o !== 5'd2) begin errors++; $display("FAIL sel_csr_waddr: got %0d expected 2", waddr_o); end
    bubble();
  endtask

  task automatic test_load_align();
    for (int i = 0; i < 9; i++) begin
      set_mem(1'b1, 1'b1, 5'd6, 2'd1, la_f3[i], {30'h0, la_off[i]}, 32'h0, 32'h0);
      tick();
      dmem_rdata_i = la_word[i];
      #1;
      checks++;
      if (wdata_o !== la_exp[i]) begin
        errors++;
        $display("FAIL load_align[%0d] f3=%0d off=%0d: got %h expected %h",
                 i, la_f3[i], la_off[i], wdata_o, la_exp[i]);
      end
    end
    bubble();
    tick();
  endtask

  task automatic test_stall_load();
    // LBU offset 1 of 0x12345678 -> 0x56
    set_mem(1'b1, 1'b1, 5'd7, 2'd1, 3'b100, 32'h0000_1001, 32'h0, 32'h0);
    stall_i = 1'b0;
    tick();
    bubble();
    dmem_rdata_i = 32'h1234_5678;
    stall_i = 1'b1;
    #1;
    checks++; if (wdata_o !== 32'h0000_0056) begin errors++; $display("FAIL stall_load_c1: got %h expected 00000056", wdata_o); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL stall_load_c1_regwrite: got %b expected 1", RegWrite); end
    tick();
    dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (wdata_o !== 32'h0000_0056) begin errors++; $display("FAIL stall_load_c2: got %h expected 00000056", wdata_o); end
    checks++; if (waddr_o !== 5'd7) begin errors++; $display("FAIL stall_load_c2_waddr: got %0d expected 7", waddr_o); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL stall_load_c2_regwrite: got %b expected 1", RegWrite); end
    tick();
    #1;
    checks++; if (wdata_o !== 32'h0000_0056) begin errors++; $display("FAIL stall_load_c3: got %h expected 00000056", wdata_o); end
    tick();
    stall_i = 1'b0;
    #1;
    checks++; if (wdata_o !== 32'h0000_0056) begin errors++; $display("FAIL stall_load_release: got %h expected 00000056", wdata_o); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL stall_load_release_regwrite: got %b expected 1", RegWrite); end
    tick();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL stall_load_after_valid: got %b expected 0", wb_valid_o); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL stall_load_after_regwrite: got %b expected 0", RegWrite); end
  endtask

  task automatic test_stall_alu();
    set_mem(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 32'h0000_A5A5, 32'h0, 32'h0);
    tick();
    set_mem(1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 32'h0000_5555, 32'h0, 32'h0);
    stall_i = 1'b1;
    tick();
    checks++; if (waddr_o !== 5'd4) begin errors++; $display("FAIL stall_alu_waddr: got %0d expected 4", waddr_o); end
    checks++; if (wdata_o !== 32'h0000_A5A5) begin errors++; $display("FAIL stall_alu_wdata: got %h expected 0000a5a5", wdata_o); end
    stall_i = 1'b0;
    tick();
    checks++; if (waddr_o !== 5'd10) begin errors++; $display("FAIL stall_alu_adv_waddr: got %0d expected 10", waddr_o); end
    checks++; if (wdata_o !== 32'h0000_5555) begin errors++; $display("FAIL stall_alu_adv_wdata: got %h expected 00005555", wdata_o); end
    bubble();
  endtask

  task automatic test_flush();
    set_mem(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h0000_0099, 32'h0, 32'h0);
    tick();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL flush_pre_regwrite: got %b expected 1", RegWrite); end
    flush_i = 1'b1;
    stall_i = 1'b1;
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL flush_stall_regwrite: got %b expected 0", RegWrite); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stall_wb_valid: got %b expected 0", wb_valid_o); end
    stall_i = 1'b0;
    set_mem(1'b1, 1'b1, 5'd11, 2'd0, 3'd0, 32'h0000_00BB, 32'h0, 32'h0);
    tick();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_only_wb_valid: got %b expected 0", wb_valid_o); end
    flush_i = 1'b0;
    bubble();
    tick();
  endtask

  task automatic test_rd_zero();
    set_mem(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h0000_0077, 32'h0, 32'h0);
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rd0_regwrite: got %b expected 0", RegWrite); end
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL rd0_wb_valid: got %b expected 1", wb_valid_o); end
    set_mem(1'b1, 1'b0, 5'd8, 2'd0, 3'd0, 32'h0000_0078, 32'h0, 32'h0);
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL no_reg_write: got %b expected 0", RegWrite); end
    bubble();
  endtask

  task automatic test_back_to_back();
    set_mem(1'b1, 1'b1, 5'd20, 2'd0, 3'd0, 32'h0000_0001, 32'h0, 32'h0);
    tick();
    set_mem(1'b1, 1'b1, 5'd21, 2'd2, 3'd0, 32'h0, 32'h0000_0400, 32'h0);
    checks++; if (wdata_o !== 32'h0000_0001 || waddr_o !== 5'd20) begin errors++; $display("FAIL b2b_0: got %0d/%h expected 20/00000001", waddr_o, wdata_o); end
    tick();
    set_mem(1'b1, 1'b1, 5'd22, 2'd1, 3'b010, 32'h0000_0010, 32'h0, 32'h0);
    checks++; if (wdata_o !== 32'h0000_0400 || waddr_o !== 5'd21) begin errors++; $display("FAIL b2b_1: got %0d/%h expected 21/00000400", waddr_o, wdata_o); end
    tick();
    bubble();
    dmem_rdata_i = 32'h0BAD_CAFE;
    #1;
    checks++; if (wdata_o !== 32'h0BAD_CAFE || waddr_o !== 5'd22) begin errors++; $display("FAIL b2b_2: got %0d/%h expected 22/0badcafe", waddr_o, wdata_o); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_mem(1'b1, 1'b1, 5'd8, 2'd1, 3'b010, 32'h0000_0000, 32'h0, 32'h0);
    tick();
    bubble();
    dmem_rdata_i = 32'h0BAD_F00D;
    stall_i = 1'b1;
    tick();
    dmem_rdata_i = 32'h0000_0000;
    #1;
    checks++; if (wdata_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_pre_held: got %h expected 0badf00d", wdata_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_async_regwrite: got %b expected 0", RegWrite); end
    checks++; if (waddr_o !== 5'd0) begin errors++; $display("FAIL rst_async_waddr: got %0d expected 0", waddr_o); end
    checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL rst_async_wdata: got %h expected 00000000", wdata_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_async_wb_valid: got %b expected 0", wb_valid_o); end
    #2;
    rst = 1'b0;
    stall_i = 1'b0;
    set_mem(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h0000_0011, 32'h0, 32'h0);
    tick();
    bubble();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL post_rst_regwrite: got %b expected 1", RegWrite); end
    checks++; if (waddr_o !== 5'd3) begin errors++; $display("FAIL post_rst_waddr: got %0d expected 3", waddr_o); end
    checks++; if (wdata_o !== 32'h0000_0011) begin errors++; $display("FAIL post_rst_wdata: got %h expected 00000011", wdata_o); end
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    dmem_rdata_i = 32'h0;
    bubble();
    test_reset();
    test_alu();
    test_wb_sel();
    test_load_align();
    test_stall_load();
    test_stall_alu();
    test_flush();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width (equals `RegBus width).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall_i  input  1  hold WB contents.
REQ-005 SHALL have port flush_i  input  1  replace WB contents with bubble.
REQ-006 SHALL have port mem_valid_i  input  1  MEM stage holds a real instruction.
REQ-007 SHALL have port mem_reg_write_i  input  1  instruction writes rd.
REQ-008 SHALL have port mem_rd_i  input  `RegAddrBus  destination register.
REQ-009 SHALL have port mem_wb_sel_i  input  2  writeback source: 0 ALU, 1 load, 2 PC+4, 3 CSR.
REQ-010 SHALL have port mem_funct3_i  input  3  load type: LB, LH, LW, LBU, LHU.
REQ-011 SHALL have ports mem_alu_result_i, mem_pc4_i, mem_csr_rdata_i  input  `RegBus  candidate results; alu_result[1:0] is load byte offset.
REQ-012 SHALL have port dmem_rdata_i  input  `RegBus  synchronous SRAM word, valid in the cycle after the address is issued.
REQ-013 SHALL have port RegWrite  output  1  register file write enable.
REQ-014 SHALL have ports waddr_o  output  `RegAddrBus and wdata_o  output  `RegBus  register file write address and data.
REQ-015 SHALL have port wb_valid_o  output  1  WB holds a real instruction (forwarding qualifier).

Function
REQ-016 SHALL latch valid, reg_write, rd, wb_sel, funct3, alu_result, pc4, csr_rdata on each rising edge with neither stall_i nor flush_i asserted.
REQ-017 SHALL give priority rst > flush_i > stall_i > normal advance; flush_i during stall_i yields a bubble.
REQ-018 SHALL, on flush_i, clear valid and reg_write; other fields don't-care.
REQ-019 SHALL, on stall_i, hold all latched fields unchanged.
REQ-020 SHALL drive RegWrite = valid & reg_write & (rd != 0); waddr_o = latched rd.
REQ-021 SHALL select wdata_o combinationally from latched fields by wb_sel; latency from MEM capture to RegWrite is one cycle.
REQ-022 SHALL align loads by offset: LB/LBU byte offset*8, LH/LHU halfword offset[1]*16, LW full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-023 SHALL treat misaligned LH/LW offsets by ignoring offset bits below access size (no trap).
REQ-024 SHALL capture aligned load data into a hold register on the first stalled cycle of a load in WB; subsequent stalled cycles and the release cycle use the held value.
REQ-025 SHALL clear the hold-valid flag when WB advances or is flushed.
REQ-026 SHALL assert RegWrite every stalled cycle; rewriting the same value is harmless.

Reset
REQ-027 SHALL on rst clear valid, reg_write, hold-valid, rd, and all data registers to 0, so RegWrite=0, waddr_o=0, wdata_o=0, wb_valid_o=0.
REQ-028 SHALL abort any in-progress hold on rst mid-stall; first post-reset instruction behaves normally.

Structure
REQ-029 SHALL take wb_sel encodings and funct3 load constants from the shared CPU package (also used by decode).
REQ-030 SHALL implement alignment/extension as combinational sub-module load_align (inputs funct3, offset, word; output XLEN data).

Verification
REQ-031 ALU op rd=5, result 0x1234_5678 -> next cycle RegWrite=1, waddr_o=5, wdata_o=0x1234_5678.
REQ-032 LB offset 3, dmem 0x80FF_0000 -> wdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080; LH offset 2 -> 0xFFFF_80FF.
REQ-033 Load rd=7 in WB, stall_i 3 cycles, dmem changes to 0xDEAD_BEEF after cycle 1 -> wdata_o stays original aligned value all 3 cycles.
REQ-034 flush_i and stall_i together on valid rd=9 write -> next cycle RegWrite=0, wb_valid_o=0.
REQ-035 rd=0 with reg_write=1 -> RegWrite=0, wb_valid_o=1.
REQ-036 rst asserted mid-stall with held load -> outputs 0 asynchronously; after release, ALU op rd=3 value 0x11 writes 0x11.
